// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the wave_gen_dds tile.
// Build option: define WAVE_DAC_CTRL_EN to send a 16-bit DAC word (control nibble,
// sample, padding) per frame instead of the bare 8-bit sample.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        WF_SINE   = 2'b00,
        WF_SAW    = 2'b01,
        WF_TRI    = 2'b10,
        WF_SQUARE = 2'b11
    } wave_t;

    // Control nibble placed ahead of the sample in the 16-bit DAC word
    localparam logic [3:0] DAC_CTRL = 4'b0011;

`ifdef WAVE_DAC_CTRL_EN
    localparam int unsigned FRAME_BITS = 16;
`else
    localparam int unsigned FRAME_BITS = 8;
`endif

    // One idle cycle before and after the data bits, two clk per bit
    localparam int unsigned FRAME_LEN = 2 * FRAME_BITS + 2;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

    // round(127*sin(2*pi*(i+0.5)/256)), first quadrant
    localparam logic [6:0] SINE_LUT [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    function automatic logic [6:0] sine_quarter(input logic [5:0] idx);
        return SINE_LUT[idx];
    endfunction

    // Word shifted out MSB-first for one frame
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] sample);
`ifdef WAVE_DAC_CTRL_EN
        return {DAC_CTRL, sample, 4'b0000};
`else
        return sample;
`endif
    endfunction

endpackage

// File: rtl/wave_spi_tx.sv
// Frame sequencer and SPI shifter for wave_gen_dds.
// Frame length follows wave_gen_pkg (WAVE_DAC_CTRL_EN selects the 16-bit DAC word).
// load pulses on the first cycle of every frame so the core can latch a new sample.
module wave_spi_tx
    import wave_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] sample,
    output logic       load,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       spi_cs
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(2 * FRAME_BITS);

    logic [CNT_W-1:0]      cnt;
    logic [FRAME_BITS-1:0] sr;
    logic                  in_bits;

    assign load    = enable && (cnt == '0);
    assign in_bits = (cnt != '0) && (cnt <= BIT_END);

    // Counter, shifter and registered SPI pins; dropping enable aborts the frame at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sr       <= '0;
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else if (!enable) begin
            cnt      <= '0;
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (load) begin
                sr <= frame_word(sample);
            end
            if (in_bits) begin
                // odd count: clock low with new data; even count: clock high, then advance
                spi_cs   <= 1'b0;
                spi_clk  <= ~cnt[0];
                spi_mosi <= sr[FRAME_BITS-1];
                if (!cnt[0]) begin
                    sr <= {sr[FRAME_BITS-2:0], 1'b0};
                end
            end else begin
                spi_cs   <= 1'b1;
                spi_clk  <= 1'b0;
                spi_mosi <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wave_gen_dds.sv
// 8-bit DDS waveform generator tile: phase accumulator, four waveforms, amplitude
// scaling, parallel output on uo_out and SPI output on uio_out[7:5].
// Build option: WAVE_DAC_CTRL_EN widens the SPI frame to a 16-bit DAC word.
module wave_gen_dds
    import wave_gen_pkg::*;
#(
    parameter int unsigned PHASE_W = 8,
    parameter int unsigned SPI_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic               enable;
    logic               set_phase;
    logic               set_amplitude;
    wave_t              wf;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] phase_inc;
    logic [7:0]         amplitude;

    logic [5:0]         idx;
    logic [7:0]         mag;
    logic [7:0]         tri_w;
    logic signed [7:0]  raw;
    logic signed [16:0] prod;
    logic [7:0]         sample_byte;

    logic               load;
    logic               spi_clk;
    logic               spi_mosi;
    logic               spi_cs;
    logic               unused_bits;

    assign enable        = uio_in[0];
    assign wf            = wave_t'(uio_in[2:1]);
    assign set_phase     = uio_in[3];
    assign set_amplitude = uio_in[4];

    // Raw signed waveform from the current phase, then amplitude scaling
    always_comb begin
        idx   = acc[6] ? ~acc[5:0] : acc[5:0];   // ~x == 63-x on 6 bits
        mag   = {1'b0, sine_quarter(idx)};
        tri_w = acc[7] ? ~{acc[6:0], 1'b0} : {acc[6:0], 1'b0};
        raw   = '0;
        unique case (wf)
            WF_SINE:   raw = acc[7] ? -mag : mag;
            WF_SAW:    raw = {~acc[7], acc[6:0]};
            WF_TRI:    raw = {~tri_w[7], tri_w[6:0]};
            WF_SQUARE: raw = acc[7] ? 8'h80 : 8'h7F;
        endcase
        // |product| <= 32640, so bits [15:8] are the floor-shifted result
        prod        = raw * $signed({1'b0, amplitude});
        sample_byte = prod[15:8] ^ 8'h80;
    end

    // Register loads run every cycle; sample and phase advance only on frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            phase_inc <= PHASE_W'(1);
            amplitude <= 8'hFF;
            uo_out    <= 8'h80;
        end else begin
            if (set_phase) begin
                phase_inc <= ui_in;
            end
            if (set_amplitude) begin
                amplitude <= ui_in;
            end
            if (load) begin
                uo_out <= sample_byte;
                acc    <= acc + phase_inc;
            end
        end
    end

    wave_spi_tx u_spi_tx (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sample   (sample_byte),
        .load     (load),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_cs   (spi_cs)
    );

    assign uio_out = {spi_clk, spi_mosi, spi_cs, 5'b00000};
    assign uio_oe  = 8'hE0;

    assign unused_bits = ^{ena, uio_in[7:5], prod[16], prod[7:0], SPI_DIV[0]};

endmodule

// File: tb/tb_wave_gen_dds.sv
// Randomized self-checking bench for wave_gen_dds against a behavioural model.
`timescale 1ns/1ps
module tb_wave_gen_dds;

`ifdef WAVE_DAC_CTRL_EN
    localparam int FBITS = 16;
`else
    localparam int FBITS = 8;
`endif
    localparam int FLEN = 2 * FBITS + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    wave_gen_dds dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    int checks = 0;
    int errors = 0;

    int sine_lut [64];
    int ref_acc, ref_inc, ref_amp;

    bit         en_r = 1'b0;
    bit         sp_r = 1'b0;
    bit         sa_r = 1'b0;
    logic [1:0] wf_r = 2'b00;

    // expected SPI words, written by stimulus, consumed by the SPI monitor
    int exp_arr [1024];
    int wr_idx = 0;
    int rd_idx = 0;
    int abort_cnt = 0;
    int abort_seen = 0;

    int cyc = 0;
    int last_fall = -1;
    int nbits = 0;
    int word = 0;
    bit prev_cs = 1'b1;
    bit prev_sclk = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_sample(input int p, input int wf, input int amp);
        int s, q, m, t, prod, y;
        case (wf)
            0: begin
                q = p % 128;
                m = (q < 64) ? sine_lut[q] : sine_lut[127 - q];
                s = (p >= 128) ? -m : m;
            end
            1: s = p - 128;
            2: begin
                t = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
                s = t - 128;
            end
            default: s = (p >= 128) ? -128 : 127;
        endcase
        prod = s * amp;
        y = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
        return (y + 128) & 255;
    endfunction

    function automatic int ref_word(input int b);
`ifdef WAVE_DAC_CTRL_EN
        return (3 << 12) | (b << 4);
`else
        return b;
`endif
    endfunction

    task automatic drive();
        uio_in = {3'b000, sa_r, sp_r, wf_r, en_r};
    endtask

    // Stop the generator and load registers over one edge
    task automatic load_regs(input int val, input bit sp, input bit sa);
        en_r = 1'b0;
        sp_r = sp;
        sa_r = sa;
        ui_in = 8'(val);
        drive();
        @(posedge clk);
        #1;
        if (sp) ref_inc = val;
        if (sa) ref_amp = val;
        sp_r = 1'b0;
        sa_r = 1'b0;
        drive();
    endtask

    task automatic frame_start(input int wf, output int b);
        @(posedge clk);
        #1;
        b = ref_sample(ref_acc, wf, ref_amp);
        check("uo_out", uo_out, b);
        exp_arr[wr_idx % 1024] = ref_word(b);
        wr_idx++;
        ref_acc = (ref_acc + ref_inc) & 255;
    endtask

    task automatic run_frames(input int n, input int wf);
        int b;
        wf_r = 2'(wf);
        en_r = 1'b1;
        drive();
        for (int f = 0; f < n; f++) begin
            frame_start(wf, b);
            repeat (FLEN - 1) @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor_step();
        bit sclk, mosi, cs;
        int e;
        cyc++;
        sclk = uio_out[7];
        mosi = uio_out[6];
        cs   = uio_out[5];
        if (!en_r) last_fall = -1;
        if (prev_cs && !cs) begin
            if (last_fall >= 0) check("frame_gap", cyc - last_fall, FLEN);
            last_fall = cyc;
            nbits = 0;
            word = 0;
        end
        if (!cs && sclk && !prev_sclk) begin
            word = (word << 1) | int'(mosi);
            nbits++;
        end
        if (cs && (sclk || mosi)) check("idle_lines", {sclk, mosi}, 0);
        if (!prev_cs && cs) begin
            if (rd_idx == wr_idx) begin
                check("spi_extra_frame", 1, 0);
            end else begin
                e = exp_arr[rd_idx % 1024];
                rd_idx++;
                if (abort_seen < abort_cnt) begin
                    abort_seen++;
                    check("abort_bits", nbits, 3);
                    check("abort_word", word, e >> (FBITS - 3));
                end else begin
                    check("spi_bits", nbits, FBITS);
                    check("spi_word", word, e);
                end
            end
        end
        prev_cs = cs;
        prev_sclk = sclk;
    endtask

    initial begin
        int b, val, mode;
        for (int i = 0; i < 64; i++) begin
            sine_lut[i] = $rtoi(127.0 * $sin(2.0 * 3.14159265358979 * (i + 0.5) / 256.0) + 0.5);
        end
        rst = 1'b1;
        ena = 1'b1;
        ui_in = 8'h00;
        drive();
        ref_acc = 0;
        ref_inc = 1;
        ref_amp = 255;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_uo_out", uo_out, 8'h80);
        check("rst_uio_out", uio_out, 8'h20);
        check("rst_uio_oe", uio_oe, 8'hE0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_uio_out", uio_out, 8'h20);
        end
        #1;

        // sawtooth ramp in steps of 0x10
        load_regs(8'h10, 1'b1, 1'b0);
        run_frames(17, 1);

        // square at half amplitude
        load_regs(8'h80, 1'b0, 1'b1);
        load_regs(8'h40, 1'b1, 1'b0);
        run_frames(8, 3);

        // triangle at the two extremes
        load_regs(8'h80, 1'b1, 1'b0);
        load_regs(8'hFF, 1'b0, 1'b1);
        run_frames(4, 2);

        // zero amplitude, every waveform
        load_regs(8'h00, 1'b0, 1'b1);
        load_regs(8'h37, 1'b1, 1'b0);
        for (int w = 0; w < 4; w++) run_frames(3, w);

        // zero increment gives a constant sample
        load_regs(8'h00, 1'b1, 1'b0);
        load_regs(8'hC3, 1'b0, 1'b1);
        run_frames(3, 0);

        // full sine sweep
        load_regs(8'h01, 1'b1, 1'b0);
        load_regs(8'hFF, 1'b0, 1'b1);
        run_frames(256, 0);

        // abort mid-frame, then resume
        load_regs(8'h10, 1'b1, 1'b0);
        wf_r = 2'd1;
        en_r = 1'b1;
        drive();
        abort_cnt++;
        frame_start(1, b);
        repeat (6) @(posedge clk);
        #1;
        en_r = 1'b0;
        drive();
        @(posedge clk);
        #1;
        check("abort_spi_pins", int'(uio_out[7:5]), 3'b001);
        repeat (5) @(posedge clk);
        #1;
        check("abort_uo_hold", uo_out, b);
        run_frames(2, 1);

        // random segments, including same-cycle phase and amplitude loads
        for (int s = 0; s < 12; s++) begin
            val = $urandom_range(0, 255);
            mode = $urandom_range(0, 2);
            load_regs(val, mode != 2, mode != 1);
            run_frames($urandom_range(2, 5), $urandom_range(0, 3));
        end

        en_r = 1'b0;
        drive();
        repeat (5) @(negedge clk);
        check("spi_frame_count", rd_idx, wr_idx);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
